// File: rtl/cnt_pkg.sv
// +----------------------------------------------------------------------------+
// | cnt_pkg                                                                    |
// | Shared enums and default widths for the parametrised counter / clkdiv.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cnt_pkg;

   typedef enum logic {
      DN = 1'b0,
      UP = 1'b1
   } cnt_dir_e;

   typedef enum logic {
      WRAP = 1'b0,
      SAT  = 1'b1
   } cnt_mode_e;

   localparam int CNT_WIDTH_DEF     = 2;
   localparam int CNT_DIV_WIDTH_DEF = 8;

endpackage : cnt_pkg

`default_nettype wire

// File: rtl/param_counter_clkdiv_if.sv
// +----------------------------------------------------------------------------+
// | param_counter_clkdiv_if                                                    |
// | Control and status bundle between the counter and its consumers.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface param_counter_clkdiv_if
   import cnt_pkg::*;
#(
   parameter int WIDTH     = CNT_WIDTH_DEF,
   parameter int DIV_WIDTH = CNT_DIV_WIDTH_DEF
);

   logic                 en;
   logic [DIV_WIDTH-1:0] div;
   logic                 dir;
   logic                 sat;
   logic                 load;
   logic [WIDTH-1:0]     load_val;
   logic [WIDTH-1:0]     count;
   logic                 tick;
   logic                 tc;
   logic                 div_out;

   modport master (
      output en,
      output div,
      output dir,
      output sat,
      output load,
      output load_val,
      input  count,
      input  tick,
      input  tc,
      input  div_out
   );

   modport slave (
      input  en,
      input  div,
      input  dir,
      input  sat,
      input  load,
      input  load_val,
      output count,
      output tick,
      output tc,
      output div_out
   );

endinterface : param_counter_clkdiv_if

`default_nettype wire

// File: rtl/param_counter_clkdiv_prescaler.sv
// +----------------------------------------------------------------------------+
// | clk_prescaler                                                              |
// | Programmable clock-enable prescaler: step every div+1 enabled cycles.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module clk_prescaler
   import cnt_pkg::*;
#(
   parameter int DIV_WIDTH = CNT_DIV_WIDTH_DEF
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 en,
   input  wire logic [DIV_WIDTH-1:0] div,
   input  wire logic                 clr,
   output logic                      step
);

   logic [DIV_WIDTH-1:0] r_psc;

   // >= rather than == so a shrinking div fires at once instead of running to wrap.
   assign step = en && (r_psc >= div);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_psc <= '0;
      end else if (clr) begin
         r_psc <= '0;
      end else if (step) begin
         r_psc <= '0;
      end else if (en) begin
         r_psc <= r_psc + DIV_WIDTH'(1);
      end
   end

endmodule : clk_prescaler

`default_nettype wire

// File: rtl/param_counter_clkdiv.sv
// +----------------------------------------------------------------------------+
// | param_counter_clkdiv                                                       |
// | Up/down wrap/saturate counter stepped by a programmable prescaler, with    |
// | tick, terminal-count and divided-clock outputs.                            |
// | Optional feature macro: CNT_LOAD_EN (synchronous load of load_val).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module param_counter_clkdiv
   import cnt_pkg::*;
#(
   parameter int WIDTH     = CNT_WIDTH_DEF,
   parameter int DIV_WIDTH = CNT_DIV_WIDTH_DEF
) (
   input  wire logic              clk,
   input  wire logic              rst,
   param_counter_clkdiv_if.slave  bus
);

   localparam logic [WIDTH-1:0] c_max = '1;

   logic             w_step;
   logic             w_load_hit;
   logic             w_up;
   logic             w_sat;
   logic [WIDTH-1:0] w_term;
   logic             w_at_term;
   logic [WIDTH-1:0] w_next_count;

   logic [WIDTH-1:0] r_count;
   logic             r_tick;
   logic             r_tc;
   logic             r_div_out;

`ifdef CNT_LOAD_EN
   assign w_load_hit = bus.load;
`else
   // Load pins stay on the interface but are deliberately left unconnected.
   logic w_unused_load;
   assign w_unused_load = ^{bus.load, bus.load_val};
   assign w_load_hit    = 1'b0;
`endif

   clk_prescaler #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .div  (bus.div),
      .clr  (w_load_hit),
      .step (w_step)
   );

   always_comb begin
      w_up         = (cnt_dir_e'(bus.dir) == UP);
      w_sat        = (cnt_mode_e'(bus.sat) == SAT);
      w_term       = w_up ? c_max : '0;
      w_at_term    = (r_count == w_term);
      w_next_count = r_count;
      if (w_at_term) begin
         // At the limit: saturate blocks the step, wrap jumps to the far end.
         if (!w_sat) begin
            w_next_count = w_up ? '0 : c_max;
         end
      end else if (w_up) begin
         w_next_count = r_count + WIDTH'(1);
      end else begin
         w_next_count = r_count - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count   <= '0;
         r_tick    <= 1'b0;
         r_tc      <= 1'b0;
         r_div_out <= 1'b0;
      end else if (w_load_hit) begin
         // Load wins over a coincident step; div_out keeps its phase.
         r_count <= bus.load_val;
         r_tick  <= 1'b0;
         r_tc    <= 1'b0;
      end else begin
         r_tick <= w_step;
         r_tc   <= w_step && w_at_term;
         if (w_step) begin
            r_count   <= w_next_count;
            r_div_out <= ~r_div_out;
         end
      end
   end

   assign bus.count   = r_count;
   assign bus.tick    = r_tick;
   assign bus.tc      = r_tc;
   assign bus.div_out = r_div_out;

endmodule : param_counter_clkdiv

`default_nettype wire

// File: tb/tb_param_counter_clkdiv.sv
// +----------------------------------------------------------------------------+
// | tb_param_counter_clkdiv                                                    |
// | Self-checking bench: directed scenarios plus random phase vs a model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_param_counter_clkdiv;

   typedef struct {
      int psc;
      int cnt;
      bit tick;
      bit tc;
      bit dout;
   } mstate_t;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   checks;
   int   errors;
   mstate_t ma;
   mstate_t mb;

   param_counter_clkdiv_if #(.WIDTH(2), .DIV_WIDTH(8)) ifa ();
   param_counter_clkdiv_if #(.WIDTH(4), .DIV_WIDTH(8)) ifb ();

   param_counter_clkdiv #(.WIDTH(2), .DIV_WIDTH(8)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ifa.slave)
   );

   param_counter_clkdiv #(.WIDTH(4), .DIV_WIDTH(8)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: count moves by +-1 modulo 2^WIDTH unless saturate blocks it.
   function automatic mstate_t model_next(mstate_t s, bit en, int div, bit dir,
                                          bit sat, bit ld, int lv, int maxv);
      mstate_t n;
      int term;
      n      = s;
      n.tick = 1'b0;
      n.tc   = 1'b0;
      if (ld) begin
         n.cnt = lv;
         n.psc = 0;
         return n;
      end
      if (!en) return n;
      if (s.psc < div) begin
         n.psc = s.psc + 1;
         return n;
      end
      n.psc  = 0;
      n.tick = 1'b1;
      n.dout = !s.dout;
      term   = dir ? maxv : 0;
      n.tc   = (s.cnt == term);
      if (!(n.tc && sat)) n.cnt = (s.cnt + (dir ? 1 : maxv)) % (maxv + 1);
      return n;
   endfunction

   function automatic bit ld_of(input logic l);
`ifdef CNT_LOAD_EN
      return l;
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or negedge rst_a) begin
      if (!rst_a) ma <= '{0, 0, 1'b0, 1'b0, 1'b0};
      else ma <= model_next(ma, ifa.en, int'(ifa.div), ifa.dir, ifa.sat,
                            ld_of(ifa.load), int'(ifa.load_val), 3);
   end

   always @(posedge clk or negedge rst_b) begin
      if (!rst_b) mb <= '{0, 0, 1'b0, 1'b0, 1'b0};
      else mb <= model_next(mb, ifb.en, int'(ifb.div), ifb.dir, ifb.sat,
                            ld_of(ifb.load), int'(ifb.load_val), 15);
   end

   always @(negedge clk) begin
      check("a_count", int'(ifa.count), ma.cnt);
      check("a_tick", int'(ifa.tick), int'(ma.tick));
      check("a_tc", int'(ifa.tc), int'(ma.tc));
      check("a_div_out", int'(ifa.div_out), int'(ma.dout));
      check("b_count", int'(ifb.count), mb.cnt);
      check("b_tick", int'(ifb.tick), int'(mb.tick));
      check("b_tc", int'(ifb.tc), int'(mb.tc));
      check("b_div_out", int'(ifb.div_out), int'(mb.dout));
   end

   initial begin
      int  c0;
      bit  d0;
      bit  found;
      checks = 0;
      errors = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.en = 1'b1; ifa.div = 8'd3; ifa.dir = 1'b1; ifa.sat = 1'b0;
      ifa.load = 1'b0; ifa.load_val = '0;
      ifb.en = 1'b1; ifb.div = 8'd0; ifb.dir = 1'b1; ifb.sat = 1'b0;
      ifb.load = 1'b0; ifb.load_val = '0;
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_count", int'(ifa.count), 0);
      check("reset_div_out", int'(ifa.div_out), 0);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Reset and prescale: div=3 up wrap
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         check("s1_count", int'(ifa.count), (k / 4) % 4);
         check("s1_tick", int'(ifa.tick), int'(k % 4 == 0));
         check("s1_tc", int'(ifa.tc), int'(k == 16));
         check("s1_div_out", int'(ifa.div_out), (k / 4) % 2);
      end

      // Down and saturate from 0 with div=0
      @(negedge clk);
      ifa.div = 8'd0; ifa.dir = 1'b0; ifa.sat = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check("s2_count", int'(ifa.count), 0);
         check("s2_tick", int'(ifa.tick), 1);
         check("s2_tc", int'(ifa.tc), 1);
         check("s2_div_out", int'(ifa.div_out), k % 2);
      end

      // Enable gating with div=1
      @(negedge clk);
      ifa.div = 8'd1; ifa.dir = 1'b1; ifa.sat = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(posedge clk); #1;
         found = ifa.tick;
      end
      check("s3_tick_seen", int'(found), 1);
      @(posedge clk); #1;
      @(negedge clk);
      ifa.en = 1'b0;
      c0 = int'(ifa.count);
      d0 = ifa.div_out;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check("s3_hold_count", int'(ifa.count), c0);
         check("s3_hold_tick", int'(ifa.tick), 0);
         check("s3_hold_div_out", int'(ifa.div_out), int'(d0));
      end
      @(negedge clk);
      ifa.en = 1'b1;
      @(posedge clk); #1;
      check("s3_resume_tick", int'(ifa.tick), 1);
      check("s3_resume_count", int'(ifa.count), (c0 + 1) % 4);

      // Div shrink: 7 -> 2 while psc=5
      @(negedge clk);
      ifa.div = 8'd7;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         found = (ma.psc == 5);
      end
      check("s4_psc5_seen", int'(found), 1);
      ifa.div = 8'd2;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         check("s4_tick", int'(ifa.tick), int'(k % 3 == 1));
      end

      // Load coincident with a step edge
      @(negedge clk);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         @(negedge clk);
         found = (ma.psc == 2);
      end
      check("s5_psc2_seen", int'(found), 1);
      c0 = int'(ifa.count);
      ifa.load = 1'b1;
      ifa.load_val = 2'd2;
      @(posedge clk); #1;
`ifdef CNT_LOAD_EN
      check("s5_load_count", int'(ifa.count), 2);
      check("s5_load_tick", int'(ifa.tick), 0);
`else
      check("s5_noload_count", int'(ifa.count), (c0 + 1) % 4);
      check("s5_noload_tick", int'(ifa.tick), 1);
`endif
      @(negedge clk);
      ifa.load = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         check("s5_next_tick", int'(ifa.tick), int'(k == 3));
      end

      // Async reset mid-run on the 4-bit instance at count=9
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         found = (mb.cnt == 9);
      end
      check("s6_cnt9_seen", int'(found), 1);
      check("s6_pre_count", int'(ifb.count), 9);
      #2;
      rst_b = 1'b0;
      #1;
      check("s6_rst_count", int'(ifb.count), 0);
      check("s6_rst_tick", int'(ifb.tick), 0);
      check("s6_rst_tc", int'(ifb.tc), 0);
      check("s6_rst_div_out", int'(ifb.div_out), 0);
      @(negedge clk);
      rst_b = 1'b1;

      // Random phase
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         ifa.en       = ($urandom_range(0, 9) != 0);
         ifa.div      = 8'($urandom_range(0, 4));
         ifa.dir      = 1'($urandom_range(0, 1));
         ifa.sat      = 1'($urandom_range(0, 1));
         ifa.load     = ($urandom_range(0, 15) == 0);
         ifa.load_val = 2'($urandom_range(0, 3));
         ifb.en       = ($urandom_range(0, 7) != 0);
         ifb.div      = 8'($urandom_range(0, 3));
         ifb.dir      = 1'($urandom_range(0, 1));
         ifb.sat      = 1'($urandom_range(0, 1));
         ifb.load     = ($urandom_range(0, 15) == 0);
         ifb.load_val = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      ifa.load = 1'b0;
      ifb.load = 1'b0;
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_param_counter_clkdiv

`default_nettype wire
